// File: rtl/btn_seq_pkg.sv
// Shared button-sequence definitions: button codes, default unlock code,
// 125 MHz phase timing constants and the player state encoding.
package btn_seq_pkg;

  localparam logic [1:0] BTN_NONE = 2'd0;
  localparam logic [1:0] BTN_1    = 2'd1;
  localparam logic [1:0] BTN_2    = 2'd2;
  localparam logic [1:0] BTN_3    = 2'd3;

  localparam logic [15:0] DEFAULT_CODE = 16'h00DE;

  localparam int CYC_500MS = 62500000;
  localparam int CYC_100MS = 12500000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } player_state_t;

  // Code 0 is a rest step and drives no button.
  function automatic logic [2:0] btn_onehot(input logic [1:0] code);
    logic [2:0] res;
    case (code)
      BTN_1:   res = 3'b001;
      BTN_2:   res = 3'b010;
      BTN_3:   res = 3'b100;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/btn_sequence_player_phase_timer.sv
// Loadable down-counter timing one ON or GAP phase; tc flags the final
// cycle of the phase (count has reached zero).
module phase_timer #(
  parameter int CNT_W = 27
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/btn_sequence_player.sv
// Plays a stored button sequence as one-hot pulses with ON/GAP timing.
// Optional tone outputs (tone_sel, tone_on) under SEQ_PLAYER_TONE_EN.
//
// state   | meaning
// ST_IDLE | waiting for start, all outputs low
// ST_ON   | driving the button of step_idx for ON_CYCLES
// ST_GAP  | all-off gap for GAP_CYCLES after each step
// ST_DONE | one-cycle done pulse after the last gap
module btn_sequence_player
  import btn_seq_pkg::*;
#(
  parameter int          SEQ_LEN    = 4,
  parameter logic [15:0] SEQ_CODE   = DEFAULT_CODE,
  parameter int          ON_CYCLES  = CYC_500MS,
  parameter int          GAP_CYCLES = CYC_100MS,
  parameter int          CNT_W      = 27
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       abort,
  output logic [2:0] btn_drive,
  output logic [2:0] led,
  output logic       busy,
  output logic       done,
  output logic [2:0] step_idx
`ifdef SEQ_PLAYER_TONE_EN
  ,
  output logic [1:0] tone_sel,
  output logic       tone_on
`endif
);

  localparam logic [2:0]       LAST_STEP = 3'(SEQ_LEN - 1);
  localparam logic [CNT_W-1:0] ON_LOAD   = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  player_state_t    state, state_nxt;
  logic [2:0]       step_nxt;
  logic [1:0]       code_nxt;
  logic             tmr_load, tmr_en, tmr_tc;
  logic [CNT_W-1:0] tmr_load_val;

  phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
    .clk      (clk),
    .clr      (clr),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_nxt    = state;
    step_nxt     = step_idx;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_en       = 1'b0;
    case (state)
      ST_IDLE: begin
        step_nxt = 3'd0;
        if (start) begin
          state_nxt    = ST_ON;
          tmr_load     = 1'b1;
          tmr_load_val = ON_LOAD;
        end
      end
      ST_ON: begin
        if (tmr_tc) begin
          state_nxt    = ST_GAP;
          tmr_load     = 1'b1;
          tmr_load_val = GAP_LOAD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_GAP: begin
        if (!tmr_tc) begin
          tmr_en = 1'b1;
        end else if (step_idx == LAST_STEP) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt    = ST_ON;
          step_nxt     = step_idx + 3'd1;
          tmr_load     = 1'b1;
          tmr_load_val = ON_LOAD;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        step_nxt  = 3'd0;
      end
      default: begin
        state_nxt = ST_IDLE;
        step_nxt  = 3'd0;
      end
    endcase
    // Abort overrides any phase transition; the timer is parked at zero.
    if (abort && (state != ST_IDLE)) begin
      state_nxt    = ST_IDLE;
      step_nxt     = 3'd0;
      tmr_load     = 1'b1;
      tmr_load_val = '0;
    end
  end

  assign code_nxt = SEQ_CODE[{step_nxt, 1'b0} +: 2];

  // Outputs are registered from next-state values so they align with state.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= ST_IDLE;
      step_idx  <= 3'd0;
      btn_drive <= 3'b000;
      led       <= 3'b000;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      step_idx  <= step_nxt;
      btn_drive <= (state_nxt == ST_ON) ? btn_onehot(code_nxt) : 3'b000;
      led       <= (state_nxt == ST_ON) ? btn_onehot(code_nxt) : 3'b000;
      busy      <= (state_nxt != ST_IDLE);
      done      <= (state_nxt == ST_DONE);
    end
  end

`ifdef SEQ_PLAYER_TONE_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      tone_sel <= BTN_NONE;
      tone_on  <= 1'b0;
    end else begin
      tone_sel <= (state_nxt == ST_ON) ? code_nxt : BTN_NONE;
      tone_on  <= (state_nxt == ST_ON) && (code_nxt != BTN_NONE);
    end
  end
`endif

endmodule

// File: tb/tb_btn_sequence_player.sv
// Bench for btn_sequence_player: two instances (default code, and a 2-step
// code with a rest step) checked every cycle against a timeline model.
module tb_btn_sequence_player;

  localparam int ON_C  = 4;
  localparam int GAP_C = 2;
  localparam int PER   = ON_C + GAP_C;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;

  always #4 clk = ~clk;

  logic [2:0] btn_a, led_a, idx_a, btn_b, led_b, idx_b;
  logic       busy_a, done_a, busy_b, done_b;
`ifdef SEQ_PLAYER_TONE_EN
  logic [1:0] tsel_a, tsel_b;
  logic       ton_a, ton_b;
`endif

  btn_sequence_player #(.SEQ_LEN(4), .SEQ_CODE(16'h00DE), .ON_CYCLES(ON_C),
                        .GAP_CYCLES(GAP_C), .CNT_W(8)) dut_a (
    .clk(clk), .clr(clr), .start(start), .abort(abort),
    .btn_drive(btn_a), .led(led_a), .busy(busy_a), .done(done_a), .step_idx(idx_a)
`ifdef SEQ_PLAYER_TONE_EN
    , .tone_sel(tsel_a), .tone_on(ton_a)
`endif
  );

  btn_sequence_player #(.SEQ_LEN(2), .SEQ_CODE(16'h0003), .ON_CYCLES(ON_C),
                        .GAP_CYCLES(GAP_C), .CNT_W(8)) dut_b (
    .clk(clk), .clr(clr), .start(start), .abort(abort),
    .btn_drive(btn_b), .led(led_b), .busy(busy_b), .done(done_b), .step_idx(idx_b)
`ifdef SEQ_PLAYER_TONE_EN
    , .tone_sel(tsel_b), .tone_on(ton_b)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: each instance is either idle or n cycles into playback (n=1 is
  // the first cycle after the start edge); outputs follow from n alone.
  int          seq_len [2] = '{4, 2};
  logic [15:0] code    [2] = '{16'h00DE, 16'h0003};
  bit          act     [2] = '{0, 0};
  int          n       [2] = '{0, 0};

  function automatic int play_len(int m);
    return seq_len[m] * PER;
  endfunction

  function automatic int code_of(int m, int s);
    return int'((code[m] >> (2 * s)) & 16'h0003);
  endfunction

  function automatic bit in_on(int m);
    return act[m] && (n[m] <= play_len(m)) && (((n[m] - 1) % PER) < ON_C);
  endfunction

  function automatic int cur_code(int m);
    return in_on(m) ? code_of(m, (n[m] - 1) / PER) : 0;
  endfunction

  function automatic logic [2:0] exp_btn(int m);
    int c = cur_code(m);
    return (c == 0) ? 3'b000 : 3'(1 << (c - 1));
  endfunction

  function automatic logic [2:0] exp_idx(int m);
    if (!act[m]) return 3'd0;
    if (n[m] > play_len(m)) return 3'(seq_len[m] - 1);
    return 3'((n[m] - 1) / PER);
  endfunction

  function automatic logic exp_done(int m);
    return act[m] && (n[m] == play_len(m) + 1);
  endfunction

  task automatic model_step(input bit s, input bit a, input bit r);
    for (int m = 0; m < 2; m++) begin
      if (r) act[m] = 0;
      else if (!act[m]) begin
        if (s) begin act[m] = 1; n[m] = 1; end
      end
      else if (a) act[m] = 0;
      else if (n[m] == play_len(m) + 1) act[m] = 0;
      else n[m]++;
    end
  endtask

  task automatic check_all();
    chk("btn_a",  32'(btn_a),  32'(exp_btn(0)));
    chk("led_a",  32'(led_a),  32'(exp_btn(0)));
    chk("busy_a", 32'(busy_a), 32'(act[0]));
    chk("done_a", 32'(done_a), 32'(exp_done(0)));
    chk("idx_a",  32'(idx_a),  32'(exp_idx(0)));
    chk("btn_b",  32'(btn_b),  32'(exp_btn(1)));
    chk("led_b",  32'(led_b),  32'(exp_btn(1)));
    chk("busy_b", 32'(busy_b), 32'(act[1]));
    chk("done_b", 32'(done_b), 32'(exp_done(1)));
    chk("idx_b",  32'(idx_b),  32'(exp_idx(1)));
`ifdef SEQ_PLAYER_TONE_EN
    chk("tsel_a", 32'(tsel_a), 32'(cur_code(0)));
    chk("ton_a",  32'(ton_a),  32'(cur_code(0) != 0));
    chk("tsel_b", 32'(tsel_b), 32'(cur_code(1)));
    chk("ton_b",  32'(ton_b),  32'(cur_code(1) != 0));
`endif
  endtask

  // Inputs change on the falling edge; outputs are checked on the next one.
  task automatic cycle(input bit s, input bit a, input bit r);
    start = s; abort = a; clr = r;
    @(posedge clk);
    model_step(s, a, r);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(0, 0, 0);
  endtask

  initial begin
    int done_cnt;
    int done_at;
    int done_at_b;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1);
    chk("rst_btn", 32'(btn_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);

    // Full playback, tracking when done appears on each instance.
    cycle(1, 0, 0);
    done_cnt = 0; done_at = 0; done_at_b = 0;
    chk("first_btn", 32'(btn_a), 32'h2);
    for (int i = 2; i <= 30; i++) begin
      cycle(0, 0, 0);
      if (done_a) begin done_cnt++; done_at = i; end
      if (done_b) done_at_b = i;
    end
    chk("done_cnt_a", 32'(done_cnt), 32'd1);
    chk("done_cyc_a", 32'(done_at), 32'd25);
    chk("done_cyc_b", 32'(done_at_b), 32'd13);

    // Start re-asserted during step 1 ON is ignored.
    cycle(1, 0, 0);
    idle(7);
    cycle(1, 0, 0);
    idle(20);

    // Abort during the gap of step 2, then a fresh start.
    cycle(1, 0, 0);
    idle(16);
    cycle(0, 1, 0);
    chk("abort_busy", 32'(busy_a), 32'h0);
    cycle(1, 0, 0);
    chk("restart_btn", 32'(btn_a), 32'h2);
    idle(26);

    // Reset mid-ON of step 3, then restart.
    cycle(1, 0, 0);
    idle(19);
    cycle(0, 0, 1);
    idle(1);
    cycle(1, 0, 0);
    idle(26);

    // Start and abort together in idle: start wins.
    cycle(1, 1, 0);
    chk("sa_busy", 32'(busy_a), 32'h1);
    idle(26);

    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0,
            $urandom_range(0, 199) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_sequence_player.md
Name: btn_sequence_player

Overview:
- Transmit-side counterpart of the button sequence detector.
- On a start pulse, plays a stored button sequence step by step. Each step drives a one-hot button pulse and lights the matching LED for a fixed on-time, followed by a gap.
- Used to demonstrate the unlock code on the board LEDs, or to drive a detector's BTN[3:1] inputs in loopback self-test.
- Sits beside the detector on the same 125 MHz clock.

Parameters:
- SEQ_LEN, 4, number of steps played (1..8).
- SEQ_CODE, 16'h00DE, packed 2-bit button codes, step 0 in bits [1:0]. Default decodes to 2,3,1,3; codes beyond SEQ_LEN are ignored. Code 0 = rest step (no button).
- ON_CYCLES, 62500000, cycles each step is driven (500 ms @ 125 MHz), must be >= 1.
- GAP_CYCLES, 12500000, cycles of all-off gap after each step (100 ms), must be >= 1.
- CNT_W, 27, phase counter width; must hold max(ON_CYCLES, GAP_CYCLES).

Ports:
- clk, input, 1, 125 MHz system clock.
- clr, input, 1, synchronous active-high reset.
- start, input, 1, begin playback; sampled only in IDLE.
- abort, input, 1, stop playback and return to IDLE.
- btn_drive, output, 3, one-hot button pulse: bit0 = BTN1, bit1 = BTN2, bit2 = BTN3.
- led, output, 3, LED mirror of btn_drive.
- busy, output, 1, high whenever not in IDLE.
- done, output, 1, one-cycle pulse after the last gap completes.
- step_idx, output, 3, index of the step currently playing.

Behaviour:
- Clocking and reset:
  - Clock is clk; reset is clr, synchronous and active-high, with priority over all other inputs.
  - Reset values: state=IDLE, btn_drive=0, led=0, busy=0, done=0, step_idx=0, counter=0.
- All outputs are registered; no combinational path from inputs to outputs.
- State machine:
  - IDLE: outputs 0. If start=1 then next state is ON with step_idx=0, counter=0, btn_drive=onehot(code[0]). A start arriving while not in IDLE is ignored.
  - ON: btn_drive and led = onehot(code[step_idx]); code 0 gives 3'b000. Counter increments every cycle. When counter=ON_CYCLES-1: go to GAP, counter=0, btn_drive=0.
  - GAP: btn_drive=0. When counter=GAP_CYCLES-1:
    - if step_idx=SEQ_LEN-1, go to DONE;
    - else step_idx+1, go to ON, counter=0.
  - DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Latency and timing:
  - btn_drive for step 0 goes high on the cycle after start is sampled.
  - Each step is high for exactly ON_CYCLES cycles and low for exactly GAP_CYCLES cycles.
  - done is asserted SEQ_LEN*(ON_CYCLES+GAP_CYCLES)+1 cycles after the start sample edge.
- abort: in any non-IDLE state, next state is IDLE with all outputs 0 and no done pulse. abort in IDLE has no effect.
- Simultaneous inputs:
  - start and abort together in IDLE: start wins.
  - clr together with anything: reset wins.
- Step to code: step_idx selects SEQ_CODE[2*step_idx +: 2]. Step counter width is 3 bits and never exceeds SEQ_LEN-1.
- No overlap or queueing: playback must complete or be aborted before the next start is accepted.

Optional Feature:
- Macro: SEQ_PLAYER_TONE_EN.
- Defined:
  - Adds output tone_sel[1:0] = the 2-bit code during ON and 0 elsewhere, registered and aligned with btn_drive.
  - Adds output tone_on = (state==ON && code!=0).
  - These drive the tone module so each button plays a distinct pitch.
- Undefined: both ports are absent; behaviour is otherwise identical.

Decomposition:
- Shared package btn_seq_pkg holds:
  - button code constants BTN_NONE=0, BTN_1=1, BTN_2=2, BTN_3=3;
  - the default code 16'h00DE;
  - 125 MHz timing constants (CYC_500MS=62500000, CYC_100MS=12500000);
  - the player state encoding (IDLE, ON, GAP, DONE).
- The detector uses the same button constants.
- One sub-module, phase_timer: load/count/terminal-count down-counter with CNT_W width, reused for the ON and GAP phases.

Test Plan (ON_CYCLES=4, GAP_CYCLES=2, default code):
1. Reset then start pulse -> btn_drive sequence 010 x4, 000 x2, 100 x4, 000 x2, 001 x4, 000 x2, 100 x4, 000 x2. done pulses once on cycle 25 after start; busy falls the cycle after.
2. Start asserted again during ON of step 1 -> ignored; sequence and done timing unchanged.
3. abort in GAP of step 2 -> next cycle busy=0, btn_drive=0, no done. A new start then replays from step 0 (btn_drive=010).
4. clr asserted mid-ON of step 3 -> next cycle all outputs 0, state IDLE; start one cycle later gives the full sequence.
5. SEQ_CODE=16'h0003 with SEQ_LEN=2 -> step 0 drives 100, step 1 is a rest step (btn_drive stays 000 for 4 cycles); done on cycle 13.
6. Loopback: btn_drive into the detector BTN[3:1], enter pulsed after done -> detector blue=1 (with SEQ_PLAYER_TONE_EN defined, tone_sel shows 2,3,1,3 during the ON phases).
